// File: rtl/seq_binary_to_bcd.sv
// Serial double-dabble binary-to-BCD converter: one add-3/shift step per clock,
// with start/busy/done handshake, sticky overflow and a leading-zero blanking mask.
module seq_binary_to_bcd #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  binary_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     lz_mask
);

    localparam int SW = 4*DIGITS + BIN_WIDTH;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     shifter, adjusted, stepped;
    logic [CW-1:0]     step_cnt;
    logic              sticky_ovf, carry_out, last_step, accept;
    logic [DIGITS-1:0] lz_nxt;

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == SHIFT) && (step_cnt == LAST_STEP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Digits are adjusted independently; the bit leaving the top digit is the overflow carry.
    always_comb begin
        adjusted = shifter;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (shifter[BIN_WIDTH + 4*i +: 4] > 4'd4)
                adjusted[BIN_WIDTH + 4*i +: 4] = shifter[BIN_WIDTH + 4*i +: 4] + 4'd3;
        end
        stepped   = {adjusted[SW-2:0], 1'b0};
        carry_out = adjusted[SW-1];
    end

    always_comb begin
        logic        zero_above;
        int unsigned d;
        zero_above = 1'b1;
        lz_nxt     = '0;
        for (int unsigned j = 0; j < DIGITS; j++) begin
            d          = DIGITS - 1 - j;
            zero_above = zero_above && (stepped[BIN_WIDTH + 4*d +: 4] == 4'd0);
            lz_nxt[d]  = zero_above && (d != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter    <= '0;
            step_cnt   <= '0;
            sticky_ovf <= 1'b0;
            bcd_out    <= '0;
            overflow   <= 1'b0;
            lz_mask    <= '0;
        end else if (accept) begin
            shifter    <= {{(4*DIGITS){1'b0}}, binary_in};
            step_cnt   <= '0;
            sticky_ovf <= 1'b0;
        end else if (state == SHIFT) begin
            shifter    <= stepped;
            step_cnt   <= step_cnt + 1'b1;
            sticky_ovf <= sticky_ovf | carry_out;
            if (last_step) begin
                bcd_out  <= stepped[SW-1 -: 4*DIGITS];
                overflow <= sticky_ovf | carry_out;
                lz_mask  <= lz_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Self-checking bench for seq_binary_to_bcd: default 14-bit/5-digit instance plus a 4-digit
// instance, compared against an arithmetic (divide/modulo) reference model.
module tb_seq_binary_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic [13:0] binary_in, binary_in4;
    logic        busy, done, overflow;
    logic        busy4, done4, overflow4;
    logic [19:0] bcd_out;
    logic [15:0] bcd_out4;
    logic [4:0]  lz_mask;
    logic [3:0]  lz_mask4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_binary_to_bcd dut (
        .clk(clk), .rst(rst), .start(start), .binary_in(binary_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow), .lz_mask(lz_mask)
    );

    seq_binary_to_bcd #(.BIN_WIDTH(14), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .binary_in(binary_in4),
        .busy(busy4), .done(done4), .bcd_out(bcd_out4), .overflow(overflow4), .lz_mask(lz_mask4)
    );

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [19:0] model_bcd(input int v, input int digits);
        logic [19:0] r = '0;
        int x = v % pow10(digits);
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] model_lz(input int v, input int digits);
        logic [4:0] m = '0;
        int x = v % pow10(digits);
        for (int i = 1; i < digits; i++) m[i] = (x < pow10(i));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Starts a conversion on the default instance and waits (bounded) for done.
    // lat = edges after the accepting edge until done is seen, -1 if it never came.
    task automatic convert(input int v, output int busy_cycles, output int lat, output bit held);
        logic [19:0] prev;
        prev = bcd_out;
        held = 1'b1;
        binary_in = 14'(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        binary_in = 14'($urandom);
        busy_cycles = 0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin lat = k; break; end
            if (busy) busy_cycles++;
            if (bcd_out !== prev) held = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; binary_in = 14'd1234;
        start4 = 1'b0; binary_in4 = '0;
        tick(); tick();
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if ({busy, done, bcd_out, overflow, lz_mask} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b bcd=%h ovf=%b lz=%b, want all 0",
                     busy, done, bcd_out, overflow, lz_mask);
        end
        checks++;
        if ({busy4, done4, bcd_out4, overflow4, lz_mask4} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state4: got busy=%b done=%b bcd=%h ovf=%b lz=%b, want all 0",
                     busy4, done4, bcd_out4, overflow4, lz_mask4);
        end
    endtask

    task automatic test_known();
        int vals[3] = '{9999, 16383, 0};
        int bc, lat;
        bit held;
        foreach (vals[n]) begin
            convert(vals[n], bc, lat, held);
            checks++;
            if (lat !== 14 || bc !== 14) begin
                errors++;
                $display("FAIL known_latency v=%0d: got lat=%0d busy=%0d, want 14/14", vals[n], lat, bc);
            end
            checks++;
            if (bcd_out !== model_bcd(vals[n], 5) || overflow !== 1'b0 || lz_mask !== model_lz(vals[n], 5)) begin
                errors++;
                $display("FAIL known_result v=%0d: got bcd=%h ovf=%b lz=%b, want bcd=%h ovf=0 lz=%b",
                         vals[n], bcd_out, overflow, lz_mask, model_bcd(vals[n], 5), model_lz(vals[n], 5));
            end
            tick();
        end
    endtask

    task automatic test_random();
        int v, bc, lat;
        bit held;
        for (int n = 0; n < 20; n++) begin
            v = int'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 2)) tick();
            convert(v, bc, lat, held);
            checks++;
            if (lat !== 14 || bc !== 14 || !held) begin
                errors++;
                $display("FAIL rand_timing v=%0d: got lat=%0d busy=%0d held=%0b, want 14/14/1", v, lat, bc, held);
            end
            checks++;
            if (bcd_out !== model_bcd(v, 5) || overflow !== 1'b0 || lz_mask !== model_lz(v, 5)) begin
                errors++;
                $display("FAIL rand_result v=%0d: got bcd=%h ovf=%b lz=%b, want bcd=%h ovf=0 lz=%b",
                         v, bcd_out, overflow, lz_mask, model_bcd(v, 5), model_lz(v, 5));
            end
            tick();
        end
    endtask

    task automatic test_digits4();
        int vals[4] = '{12000, 9999, 10000, 16383};
        int lat;
        logic [19:0] eb;
        logic [4:0]  el;
        foreach (vals[n]) begin
            binary_in4 = 14'(vals[n]);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            lat = -1;
            for (int k = 0; k < 60; k++) begin
                if (done4) begin lat = k; break; end
                tick();
            end
            eb = model_bcd(vals[n], 4);
            el = model_lz(vals[n], 4);
            checks++;
            if (lat !== 14 || bcd_out4 !== eb[15:0] || overflow4 !== (vals[n] >= 10000) || lz_mask4 !== el[3:0]) begin
                errors++;
                $display("FAIL digits4 v=%0d: got lat=%0d bcd=%h ovf=%b lz=%b, want lat=14 bcd=%h ovf=%b lz=%b",
                         vals[n], lat, bcd_out4, overflow4, lz_mask4, eb[15:0], (vals[n] >= 10000), el[3:0]);
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        logic [19:0] got = '0;
        binary_in = 14'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        binary_in = 14'd4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin pulses++; got = bcd_out; end
            tick();
        end
        checks++;
        if (pulses !== 1 || got !== 20'h01234) begin
            errors++;
            $display("FAIL start_ignored: got pulses=%0d bcd=%h, want 1 and 01234", pulses, got);
        end
        checks++;
        if (bcd_out !== 20'h01234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got bcd=%h busy=%b, want 01234 busy=0", bcd_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        logic [19:0] r1 = '0, r2 = '0;
        binary_in = 14'd42;
        start = 1'b1;
        tick();
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                if (first < 0) begin
                    first = k; r1 = bcd_out; binary_in = 14'd77;
                end else begin
                    second = k; r2 = bcd_out; start = 1'b0;
                    break;
                end
            end
            tick();
        end
        tick();
        checks++;
        if (first !== 14 || second !== 29) begin
            errors++;
            $display("FAIL b2b_spacing: got done at %0d,%0d, want 14,29", first, second);
        end
        checks++;
        if (r1 !== 20'h00042 || r2 !== 20'h00077) begin
            errors++;
            $display("FAIL b2b_results: got %h,%h, want 00042,00077", r1, r2);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, bc, lat;
        bit held;
        binary_in = 14'd9876;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, bcd_out, overflow, lz_mask} !== 28'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b lz=%b, want all 0",
                     busy, done, bcd_out, overflow, lz_mask);
        end
        for (int k = 0; k < 20; k++) begin
            if (done || busy) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d busy/done cycles, want 0", pulses);
        end
        convert(500, bc, lat, held);
        checks++;
        if (lat !== 14 || bcd_out !== 20'h00500 || lz_mask !== 5'b11000) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d bcd=%h lz=%b, want 14 00500 11000", lat, bcd_out, lz_mask);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_known();
        test_random();
        test_digits4();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
